// File: rtl/line_window_3x3_pkg.sv
// Shared constants for the 3x3 line-window block: window geometry, tap indices
// and the encoding of which row buffer currently holds the oldest row.
package line_win_pkg;

  localparam int LW_K    = 3;
  localparam int LW_TAPS = 9;

  // Row-major tap indices: top row is y-2, left column is x-2.
  localparam int LW_TL = 0;
  localparam int LW_TM = 1;
  localparam int LW_TR = 2;
  localparam int LW_ML = 3;
  localparam int LW_MM = 4;
  localparam int LW_MR = 5;
  localparam int LW_BL = 6;
  localparam int LW_BM = 7;
  localparam int LW_BR = 8;

  localparam logic [1:0] LW_ROWS_FULL = 2'd2;

  typedef enum logic {
    SEL_RAM1_OLD = 1'b0,
    SEL_RAM2_OLD = 1'b1
  } lw_sel_e;

  function automatic logic [1:0] lw_rows_inc(input logic [1:0] rows);
    return (rows == LW_ROWS_FULL) ? LW_ROWS_FULL : rows + 2'd1;
  endfunction

endpackage

// File: rtl/line_window_3x3_if.sv
// Pixel-in / window-out stream of line_window_3x3. m_err exists only when
// LINE_WIN_ERR_CHK_EN is defined.
// Handshake: s_valid qualifies s_sof/s_eol/s_data and is always accepted (no
// ready); m_valid is a one-cycle strobe qualifying m_win (and has no ready).
interface line_window_3x3_if #(
  parameter int DW = 8
);
  logic              s_valid;
  logic              s_sof;
  logic              s_eol;
  logic [DW-1:0]     s_data;
  logic              m_valid;
  logic [9*DW-1:0]   m_win;
`ifdef LINE_WIN_ERR_CHK_EN
  logic              m_err;

  modport master (output s_valid, s_sof, s_eol, s_data,
                  input  m_valid, m_win, m_err);
  modport slave  (input  s_valid, s_sof, s_eol, s_data,
                  output m_valid, m_win, m_err);
`else
  modport master (output s_valid, s_sof, s_eol, s_data,
                  input  m_valid, m_win);
  modport slave  (input  s_valid, s_sof, s_eol, s_data,
                  output m_valid, m_win);
`endif
endinterface

// File: rtl/line_window_3x3_shift3x3.sv
// 3x3 window register array: each shift pushes a new {top,mid,bot} column in
// on the right; clr zeroes the older columns (and everything if not shifting).
module line_win_shift3x3
  import line_win_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift,
  input  logic [DW-1:0]         col_top,
  input  logic [DW-1:0]         col_mid,
  input  logic [DW-1:0]         col_bot,
  output logic [LW_TAPS*DW-1:0] win
);

  logic [DW-1:0] tap [LW_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LW_TAPS; i++) tap[i] <= '0;
    end else if (shift) begin
      tap[LW_TL] <= clr ? '0 : tap[LW_TM];
      tap[LW_TM] <= clr ? '0 : tap[LW_TR];
      tap[LW_TR] <= col_top;
      tap[LW_ML] <= clr ? '0 : tap[LW_MM];
      tap[LW_MM] <= clr ? '0 : tap[LW_MR];
      tap[LW_MR] <= col_mid;
      tap[LW_BL] <= clr ? '0 : tap[LW_BM];
      tap[LW_BM] <= clr ? '0 : tap[LW_BR];
      tap[LW_BR] <= col_bot;
    end else if (clr) begin
      for (int i = 0; i < LW_TAPS; i++) tap[i] <= '0;
    end
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < LW_TAPS; k++) win[k*DW +: DW] = tap[k];
  end

endmodule

// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator using two single-port row buffers as
// rotating line stores. Optional row-length checker: LINE_WIN_ERR_CHK_EN.
module line_window_3x3
  import line_win_pkg::*;
#(
  parameter int P_ROW_WIDTH  = 256,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 12
) (
  input  logic                    clka,
  input  logic                    rsta_n,
  line_window_3x3_if.slave        s,
  output logic                    ram1_ena,
  output logic                    ram1_wea,
  output logic [P_ADDR_WIDTH-1:0] ram1_addra,
  output logic [P_DATA_WIDTH-1:0] ram1_dina,
  input  logic [P_DATA_WIDTH-1:0] ram1_douta,
  output logic                    ram2_ena,
  output logic                    ram2_wea,
  output logic [P_ADDR_WIDTH-1:0] ram2_addra,
  output logic [P_DATA_WIDTH-1:0] ram2_dina,
  input  logic [P_DATA_WIDTH-1:0] ram2_douta
);

  localparam logic [P_ADDR_WIDTH-1:0] COL_LAST  = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
  localparam logic [P_ADDR_WIDTH-1:0] COL_FIRST = P_ADDR_WIDTH'(2);

  logic [P_ADDR_WIDTH-1:0] col;
  logic [1:0]              rows;
  lw_sel_e                 sel;

  // s_sof restarts the frame on the very pixel that carries it.
  logic [P_ADDR_WIDTH-1:0] eff_col;
  logic [1:0]              eff_rows;
  lw_sel_e                 eff_sel;
  logic                    row_end;

  assign eff_col  = s.s_sof ? '0 : col;
  assign eff_rows = s.s_sof ? 2'd0 : rows;
  assign eff_sel  = s.s_sof ? SEL_RAM1_OLD : sel;
  assign row_end  = (eff_col == COL_LAST);

  // The old-row buffer is overwritten with the current pixel (READ_FIRST
  // returns the y-2 pixel); the other buffer is only read for row y-1.
  always_comb begin
    ram1_ena   = 1'b0;
    ram1_wea   = 1'b0;
    ram1_addra = '0;
    ram1_dina  = '0;
    ram2_ena   = 1'b0;
    ram2_wea   = 1'b0;
    ram2_addra = '0;
    ram2_dina  = '0;
    if (s.s_valid) begin
      ram1_ena   = 1'b1;
      ram2_ena   = 1'b1;
      ram1_addra = eff_col;
      ram2_addra = eff_col;
      if (eff_sel == SEL_RAM1_OLD) begin
        ram1_wea  = 1'b1;
        ram1_dina = s.s_data;
      end else begin
        ram2_wea  = 1'b1;
        ram2_dina = s.s_data;
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      col  <= '0;
      rows <= 2'd0;
      sel  <= SEL_RAM1_OLD;
    end else if (s.s_valid) begin
      if (row_end) begin
        col  <= '0;
        rows <= lw_rows_inc(eff_rows);
        sel  <= (eff_sel == SEL_RAM1_OLD) ? SEL_RAM2_OLD : SEL_RAM1_OLD;
      end else begin
        col  <= eff_col + 1'b1;
        rows <= eff_rows;
        sel  <= eff_sel;
      end
    end
  end

  // Align stage: holds the accepted pixel for the cycle its row data is on douta.
  logic                    d_valid;
  logic                    d_sof;
  logic                    d_emit;
  lw_sel_e                 d_sel;
  logic [P_DATA_WIDTH-1:0] d_data;
  logic                    m_valid_q;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      d_valid   <= 1'b0;
      d_sof     <= 1'b0;
      d_emit    <= 1'b0;
      d_sel     <= SEL_RAM1_OLD;
      d_data    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      d_valid   <= s.s_valid;
      m_valid_q <= d_valid & d_emit;
      if (s.s_valid) begin
        d_sof  <= s.s_sof;
        d_emit <= (eff_rows == LW_ROWS_FULL) && (eff_col >= COL_FIRST);
        d_sel  <= eff_sel;
        d_data <= s.s_data;
      end
    end
  end

  logic [P_DATA_WIDTH-1:0] top_px;
  logic [P_DATA_WIDTH-1:0] mid_px;

  assign top_px = (d_sel == SEL_RAM1_OLD) ? ram1_douta : ram2_douta;
  assign mid_px = (d_sel == SEL_RAM1_OLD) ? ram2_douta : ram1_douta;

  line_win_shift3x3 #(.DW(P_DATA_WIDTH)) u_shift (
    .clk     (clka),
    .rst_n   (rsta_n),
    .clr     (d_valid & d_sof),
    .shift   (d_valid),
    .col_top (top_px),
    .col_mid (mid_px),
    .col_bot (d_data),
    .win     (s.m_win)
  );

  assign s.m_valid = m_valid_q;

`ifdef LINE_WIN_ERR_CHK_EN
  logic m_err_q;

  // Sticky until the next frame start; a bad s_sof pixel still sets it.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      m_err_q <= 1'b0;
    end else if (s.s_valid) begin
      m_err_q <= (s.s_sof ? 1'b0 : m_err_q) | (s.s_eol != row_end);
    end
  end

  assign s.m_err = m_err_q;
`else
  logic unused_eol;
  assign unused_eol = s.s_eol;
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 with 8-pixel rows and READ_FIRST row-buffer
// models; windows are checked against an image-based expected queue.
module tb_line_window_3x3;

  localparam int W  = 8;
  localparam int DW = 8;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rsta_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  line_window_3x3_if #(.DW(DW)) bus ();

  logic          ram1_ena, ram1_wea, ram2_ena, ram2_wea;
  logic [AW-1:0] ram1_addra, ram2_addra;
  logic [DW-1:0] ram1_dina, ram2_dina;
  logic [DW-1:0] ram1_douta = '0;
  logic [DW-1:0] ram2_douta = '0;

  line_window_3x3 #(.P_ROW_WIDTH(W), .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .clka       (clk),
    .rsta_n     (rsta_n),
    .s          (bus),
    .ram1_ena   (ram1_ena),
    .ram1_wea   (ram1_wea),
    .ram1_addra (ram1_addra),
    .ram1_dina  (ram1_dina),
    .ram1_douta (ram1_douta),
    .ram2_ena   (ram2_ena),
    .ram2_wea   (ram2_wea),
    .ram2_addra (ram2_addra),
    .ram2_dina  (ram2_dina),
    .ram2_douta (ram2_douta)
  );

  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram1_ena) begin
      ram1_douta <= mem1[ram1_addra];
      if (ram1_wea) mem1[ram1_addra] <= ram1_dina;
    end
    if (ram2_ena) begin
      ram2_douta <= mem2[ram2_addra];
      if (ram2_wea) mem2[ram2_addra] <= ram2_dina;
    end
  end

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  logic [9*DW-1:0] exp_q[$];
  int              cyc_q[$];
  logic [DW-1:0]   img [0:7][0:7];
  int              win_cnt = 0;
  logic [9*DW-1:0] first_win, last_win, ew;
  int              ec;

  function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = img[r-2+k/3][c-2+k%3];
    return w;
  endfunction

  always @(negedge clk) begin
    if (rsta_n && bus.m_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_window: got m_win=%h at cycle %0d, expected no window", bus.m_win, cyc);
      end else begin
        ew = exp_q.pop_front();
        ec = cyc_q.pop_front();
        if (bus.m_win !== ew || cyc != ec) begin
          failures++;
          $display("FAIL window: got m_win=%h at cycle %0d, expected %h at cycle %0d", bus.m_win, cyc, ew, ec);
        end
      end
      if (win_cnt == 0) first_win = bus.m_win;
      last_win = bus.m_win;
      win_cnt++;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic present(input logic sof, input logic eol, input logic [DW-1:0] d, input int r, input int c);
    bus.s_valid = 1'b1;
    bus.s_sof   = sof;
    bus.s_eol   = eol;
    bus.s_data  = d;
    img[r][c]   = d;
    #1;
  endtask

  task automatic accept(input int r, input int c);
    @(posedge clk);
    #1;
    // m_valid is sampled in the cycle after the second edge counting the accept edge
    if (r >= 2 && c >= 2) begin
      exp_q.push_back(exp_win(r, c));
      cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic send(input logic sof, input logic eol, input logic [DW-1:0] d, input int r, input int c);
    present(sof, eol, d, r, c);
    accept(r, c);
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_eol   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int nrows, input logic [DW-1:0] base, input int max_gap, input logic with_sof);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < W; c++) begin
        send(with_sof && r == 0 && c == 0, c == W-1, base | DW'(r*16 + c), r, c);
        if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
    idle(1);
  endtask

  task automatic drain(input string name, input int want_cnt);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d windows still pending, expected 0", name, exp_q.size());
    end
    checks++;
    if (win_cnt != want_cnt) begin
      failures++;
      $display("FAIL %s_count: got %0d windows, expected %0d", name, win_cnt, want_cnt);
    end
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_eol   = 1'b0;
    bus.s_data  = '0;
    rsta_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_win !== '0) begin
      failures++;
      $display("FAIL reset_out: got m_valid=%b m_win=%h, expected 0 and 0", bus.m_valid, bus.m_win);
    end
    checks++;
    if ({ram1_ena, ram1_wea, ram2_ena, ram2_wea} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ram: got ena1/wea1/ena2/wea2=%b, expected 0000",
               {ram1_ena, ram1_wea, ram2_ena, ram2_wea});
    end
    rsta_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_window();
    win_cnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        present(r == 0 && c == 0, c == W-1, DW'(r*16 + c), r, c);
        if (r == 1 && c == 0) begin
          checks++;
          if (ram2_wea !== 1'b1 || ram1_wea !== 1'b0 || ram1_ena !== 1'b1 || ram2_ena !== 1'b1) begin
            failures++;
            $display("FAIL ram_row1_sel: got ena1=%b wea1=%b ena2=%b wea2=%b, expected 1 0 1 1",
                     ram1_ena, ram1_wea, ram2_ena, ram2_wea);
          end
        end
        if (r == 2 && c == 3) begin
          checks++;
          if (ram1_ena !== 1'b1 || ram1_wea !== 1'b1 || ram1_addra !== AW'(3) || ram1_dina !== 8'h23 ||
              ram2_ena !== 1'b1 || ram2_wea !== 1'b0 || ram2_addra !== AW'(3)) begin
            failures++;
            $display("FAIL ram_row2_col3: got ram1 %b%b a=%0d d=%h ram2 %b%b a=%0d, expected ram1 11 a=3 d=23 ram2 10 a=3",
                     ram1_ena, ram1_wea, ram1_addra, ram1_dina, ram2_ena, ram2_wea, ram2_addra);
          end
        end
        accept(r, c);
      end
    idle(1);
    drain("first_window", 12);
    checks++;
    if (first_win !== 72'h22_21_20_12_11_10_02_01_00) begin
      failures++;
      $display("FAIL first_window: got %h, expected 222120121110020100", first_win);
    end
    checks++;
    if (last_win !== 72'h37_36_35_27_26_25_17_16_15) begin
      failures++;
      $display("FAIL last_window: got %h, expected 373635272625171615", last_win);
    end
    checks++;
    if (ram1_ena !== 1'b0 || ram2_ena !== 1'b0) begin
      failures++;
      $display("FAIL idle_ena: got ena1=%b ena2=%b, expected 0 0", ram1_ena, ram2_ena);
    end
  endtask

  task automatic test_gaps();
    win_cnt = 0;
    send_frame(4, 8'h00, 2, 1'b1);
    drain("gaps", 12);
    checks++;
    if (first_win !== 72'h22_21_20_12_11_10_02_01_00) begin
      failures++;
      $display("FAIL gaps_first_window: got %h, expected 222120121110020100", first_win);
    end
  endtask

  task automatic test_sof_mid_row();
    win_cnt = 0;
    // Old frame carries bit 7 so any leak into the new frame's windows shows.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 4) break;
        send(r == 0 && c == 0, c == W-1, 8'h80 | DW'(r*16 + c), r, c);
      end
    send_frame(4, 8'h00, 0, 1'b1);
    drain("sof_mid_row", 14);
    checks++;
    if (last_win !== 72'h37_36_35_27_26_25_17_16_15) begin
      failures++;
      $display("FAIL sof_last_window: got %h, expected 373635272625171615", last_win);
    end
  endtask

  task automatic test_reset_mid_frame();
    win_cnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 3 && c == 4) break;
        send(r == 0 && c == 0, c == W-1, 8'h40 | DW'(r*16 + c), r, c);
      end
    idle(3);
    drain("pre_reset", 8);
    rsta_n = 1'b0;
    #2;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_win !== '0 || ram1_ena !== 1'b0 || ram2_ena !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got m_valid=%b m_win=%h ena1=%b ena2=%b, expected all 0",
               bus.m_valid, bus.m_win, ram1_ena, ram2_ena);
    end
    @(posedge clk);
    #1;
    rsta_n = 1'b1;
    win_cnt = 0;
    // No s_sof: counters must already be at column 0, row 0 after reset.
    send_frame(4, 8'h00, 0, 1'b0);
    drain("post_reset", 12);
    checks++;
    if (first_win !== 72'h22_21_20_12_11_10_02_01_00) begin
      failures++;
      $display("FAIL post_reset_first_window: got %h, expected 222120121110020100", first_win);
    end
  endtask

`ifdef LINE_WIN_ERR_CHK_EN
  task automatic test_err();
    send_frame(2, 8'h00, 0, 1'b1);
    checks++;
    if (bus.m_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clean_frame: got m_err=%b, expected 0", bus.m_err);
    end
    for (int c = 0; c < W; c++) begin
      send(c == 0, c == 5, DW'(c), 0, c);
      if (c == 4) begin
        checks++;
        if (bus.m_err !== 1'b0) begin
          failures++;
          $display("FAIL err_before_eol: got m_err=%b, expected 0", bus.m_err);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.m_err !== 1'b1) begin
          failures++;
          $display("FAIL err_set: got m_err=%b, expected 1", bus.m_err);
        end
      end
    end
    idle(2);
    checks++;
    if (bus.m_err !== 1'b1) begin
      failures++;
      $display("FAIL err_hold: got m_err=%b, expected 1", bus.m_err);
    end
    send(1'b1, 1'b0, 8'h00, 0, 0);
    checks++;
    if (bus.m_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear_sof: got m_err=%b, expected 0", bus.m_err);
    end
    for (int c = 1; c < W; c++) send(1'b0, c == W-1, DW'(c), 0, c);
    idle(1);
    checks++;
    if (bus.m_err !== 1'b0) begin
      failures++;
      $display("FAIL err_after_clean_row: got m_err=%b, expected 0", bus.m_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_window();
    test_gaps();
    test_sof_mid_row();
    test_reset_mid_frame();
`ifdef LINE_WIN_ERR_CHK_EN
    test_err();
`endif
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
